// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Feeds the repeated-addition multiplier. Operand pairs from a producer are
//   buffered in a DEPTH-entry FIFO and presented on the multiplier's shared
//   data_in bus as A (with a one-cycle start strobe), then B. The sequencer
//   then waits for mul_done, captures the product, and offers it to a consumer
//   over a valid/ready handshake.
//
//   Optional feature macro: MUL_TIMEOUT_EN
//     When defined, a WAIT longer than TIMEOUT_CYCLES cycles ends with an
//     all-ones result and sets the sticky err flag. When undefined, WAIT is
//     unbounded and err is tied low.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      producer offers {in_a, in_b}
//   in_ready      FIFO not full (from registered occupancy only)
//   in_a, in_b    multiplicand / multiplier operands
//   data_out      drives multiplier data_in (A, then B, held during WAIT)
//   start         one-cycle strobe to the multiplier controller
//   mul_done      multiplier done level (only observed in WAIT)
//   mul_product   multiplier product
//   res_valid     captured product available
//   res_ready     consumer accepts the product
//   res_data      captured product
//   level         FIFO occupancy
//   busy          sequencer is not idle
//   err           sticky timeout flag
module mul_operand_sequencer #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         data_out,
    output logic                     start,
    input  logic                     mul_done,
    input  logic [WIDTH-1:0]         mul_product,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("mul_operand_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0]   head_a, head_b;
    logic [WIDTH-1:0]   b_hold;
    logic [WIDTH-1:0]   res_q;
    logic               push, pop, capture, timeout;

    assign head_a   = mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign head_b   = mem[rd_ptr][WIDTH-1:0];
    assign in_ready = (level != FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_LOAD_B);
    assign capture  = (state_q == S_WAIT) && mul_done;
    assign busy     = (state_q != S_IDLE);
    assign res_data = res_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (level != '0) state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_WAIT;
            S_WAIT:   if (capture || timeout) state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        data_out  = '0;
        start     = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                data_out = head_a;
                start    = 1'b1;
            end
            S_LOAD_B: data_out = head_b;
            // head has already been popped, so WAIT drives the saved copy of B
            S_WAIT:   data_out = b_hold;
            S_RESULT: res_valid = 1'b1;
            default:  ;
        endcase
    end

    // FIFO storage (contents need no reset; pointers and level do)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            b_hold <= '0;
            res_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                b_hold <= head_b;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
            if (capture) begin
                res_q <= mul_product;
            end else if (timeout) begin
                res_q <= '1;
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Counter sits at zero outside WAIT, so it is already clear on entry.
    assign timeout = (state_q == S_WAIT) && !mul_done && (wait_cnt == LAST_WAIT);
    assign err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q != S_WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer. A transaction-level reference
// (queue of accepted pairs, pushed/popped counts, operation phase) predicts
// the sequencer's outputs; a responder plays the multiplier and a monitor
// compares every cycle and scores each accepted result against a queue.
module tb_mul_operand_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef MUL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic [WIDTH-1:0]  data_out;
    logic              start;
    logic              mul_done = 1'b0;
    logic [WIDTH-1:0]  mul_product = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [WIDTH-1:0]  res_data;
    logic [2:0]        level;
    logic              busy;
    logic              err;

    mul_operand_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .data_out(data_out),
        .start(start),
        .mul_done(mul_done),
        .mul_product(mul_product),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .level(level),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state. ph: 0 idle, 1 issuing A, 2 issuing B, 3 waiting, 4 result.
    logic [31:0] pair_q[$];
    logic [15:0] res_q[$];
    logic [31:0] cur = '0;
    logic [15:0] exp_res = '0;
    int ph = 0;
    int wait_cnt = 0;
    int pushes = 0;
    int pops = 0;
    bit err_m = 1'b0;
    // Responder: 0 = done after `delay` WAIT cycles, 1 = done held high, 2 = never done
    int mode = 0;
    int delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference update on each clock edge, from bench-driven inputs only.
    always @(posedge clk) begin : model
        int lvl;
        if (rst) begin
            pair_q.delete();
            res_q.delete();
            ph = 0;
            wait_cnt = 0;
            pushes = 0;
            pops = 0;
            err_m = 1'b0;
        end else begin
            lvl = pushes - pops;
            case (ph)
                0: if (lvl > 0) begin
                    cur = pair_q.pop_front();
                    ph = 1;
                end
                1: ph = 2;
                2: begin
                    ph = 3;
                    pops++;
                    wait_cnt = 0;
                end
                3: if (mul_done) begin
                    exp_res = cur[31:16] * cur[15:0];
                    res_q.push_back(exp_res);
                    ph = 4;
                end else begin
                    wait_cnt++;
`ifdef MUL_TIMEOUT_EN
                    if (wait_cnt == TO) begin
                        exp_res = 16'hFFFF;
                        res_q.push_back(exp_res);
                        err_m = 1'b1;
                        ph = 4;
                    end
`endif
                end
                4: if (res_ready) ph = 0;
                default: ph = 0;
            endcase
            if (in_valid && lvl < DEPTH) begin
                pair_q.push_back({in_a, in_b});
                pushes++;
            end
        end
    end

    // Multiplier responder and output monitor, one time unit after the falling edge.
    always @(negedge clk) begin : mon
        int lvl;
        logic [15:0] prod;
        logic [15:0] exp_do;
        #1;
        if (!rst) begin
            lvl  = pushes - pops;
            prod = cur[31:16] * cur[15:0];
            if (ph == 3 && ((mode == 0 && wait_cnt >= delay) || mode == 1)) begin
                mul_done    = 1'b1;
                mul_product = prod;
            end else begin
                mul_done    = (mode == 1);
                mul_product = 16'($urandom);
            end

            case (ph)
                1:       exp_do = cur[31:16];
                2, 3:    exp_do = cur[15:0];
                default: exp_do = '0;
            endcase

            check("level", 32'(level), 32'(lvl));
            check("in_ready", 32'(in_ready), 32'(lvl < DEPTH));
            check("start", 32'(start), 32'(ph == 1));
            check("busy", 32'(busy), 32'(ph != 0));
            check("data_out", 32'(data_out), 32'(exp_do));
            check("res_valid", 32'(res_valid), 32'(ph == 4));
            check("err", 32'(err), 32'(err_m));
            if (ph == 4) check("res_data_held", 32'(res_data), 32'(exp_res));

            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL res_unexpected: got %0h expected none at %0t", res_data, $time);
                end else begin
                    check("res_data", 32'(res_data), 32'(res_q.pop_front()));
                end
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (!(ph == 0 && pushes == pops) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_phase(input int target, input int max_cycles);
        int n = 0;
        while (ph != target && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: got phase %0d expected %0d", ph, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h0);
        check({tag, "_start"}, 32'(start), 32'h0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'h0);
        check({tag, "_res_data"}, 32'(res_data), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_level"}, 32'(level), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Single operation 5 x 3, done raised in the eighth WAIT cycle
        mode = 0;
        delay = 7;
        res_ready = 1'b1;
        push(16'd5, 16'd3);
        wait_idle(100);

        // Fill the FIFO while the multiplier stalls; extra offers must be refused
        mode = 2;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 16'(i + 1);
            in_b = 16'(i + 10);
            @(negedge clk);
        end
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'h0);
        mode = 0;
        delay = 1;
        res_ready = 1'b1;
        wait_idle(200);

        // Result held for 5 cycles, then exactly one idle cycle before next LOAD_A
        delay = 2;
        res_ready = 1'b0;
        push(16'd6, 16'd11);
        push(16'd7, 16'd9);
        wait_phase(4, 40);
        for (int i = 0; i < 5; i++) begin
            check("hold_res_data", 32'(res_data), 32'h0042);
            check("hold_res_valid", 32'(res_valid), 32'h1);
            check("hold_no_start", 32'(start), 32'h0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("gap_busy", 32'(busy), 32'h0);
        check("gap_start", 32'(start), 32'h0);
        @(negedge clk);
        check("next_start", 32'(start), 32'h1);
        check("next_data_a", 32'(data_out), 32'd7);
        wait_idle(100);

        // mul_done held high throughout: capture only in the first WAIT cycle
        mode = 1;
        push(16'd12, 16'd13);
        push(16'd0, 16'd77);
        push(16'hFFFF, 16'hFFFF);
        wait_idle(100);
        mode = 0;

        // Randomised traffic with zero operands and consumer back-pressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            delay     = $urandom_range(0, 5);
            mode      = ($urandom_range(0, 4) == 0) ? 1 : 0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        mode = 0;
        wait_idle(300);

        // Asynchronous reset while waiting with two pairs still queued
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'(100 + i);
            in_b = 16'(200 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!(ph == 3 && pushes - pops == 2) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                vectors++;
                miscompares++;
                $display("FAIL reach_wait: got phase %0d level %0d expected 3/2", ph, pushes - pops);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        mode = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_rst_res_valid", 32'(res_valid), 32'h0);
            check("post_rst_level", 32'(level), 32'h0);
        end
        mode = 0;

`ifdef MUL_TIMEOUT_EN
        // Timeout: all-ones result, sticky err across the handshake
        mode = 2;
        res_ready = 1'b0;
        push(16'd9, 16'd9);
        wait_phase(4, 40);
        check("timeout_res_data", 32'(res_data), 32'hFFFF);
        check("timeout_err", 32'(err), 32'h1);
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("timeout_err_sticky", 32'(err), 32'h1);
        mode = 0;
        wait_idle(50);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
